// File: rtl/noc_local_injector_if.sv
// PE-to-injector message channel and injector-to-router Local flit channel.
// Handshake (both channels): a beat transfers on a rising clk edge where valid && ready; the sender holds valid and its payload stable until that edge, and ready never depends on valid.
interface noc_local_injector_if;
  logic        pe_valid;
  logic        pe_ready;
  logic [3:0]  pe_dest_x;
  logic [3:0]  pe_dest_y;
  logic [31:0] pe_payload;
  logic        rtr_valid;
  logic        rtr_ready;
  logic [1:0]  rtr_type;
  logic [15:0] rtr_data;

  // master: the injector's view (it drives the router channel, receives from the PE)
  modport master (
    input  pe_valid, pe_dest_x, pe_dest_y, pe_payload, rtr_ready,
    output pe_ready, rtr_valid, rtr_type, rtr_data
  );

  // slave: the surrounding PE + router environment
  modport slave (
    output pe_valid, pe_dest_x, pe_dest_y, pe_payload, rtr_ready,
    input  pe_ready, rtr_valid, rtr_type, rtr_data
  );
endinterface

// File: rtl/noc_local_injector.sv
// NoC injection stage: queues PE messages in a FIFO and serializes each into a head/body/tail worm.
// Optional macro NI_STATS_EN adds pkt_count / stall_count statistics outputs.
module noc_local_injector #(
  parameter logic [3:0] XCOORD = 4'b0001,
  parameter logic [3:0] YCOORD = 4'b0001,
  parameter int         DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  noc_local_injector_if.master   bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [1:0]             dbg_state
`ifdef NI_STATS_EN
  ,
  output logic [15:0]            pkt_count,
  output logic [15:0]            stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 40;

  typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, BODY = 2'd2, TAIL = 2'd3} state_e;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop, xfer;
  logic [EW-1:0] head_entry, pkt_q, pkt_d;
  state_e        state_q, state_d;
  logic          rtr_valid_q, rtr_valid_d;
  logic [1:0]    rtr_type_q, rtr_type_d;
  logic [15:0]   rtr_data_q, rtr_data_d;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign push         = bus.pe_valid && !full;
  assign xfer         = rtr_valid_q && bus.rtr_ready;
  assign head_entry   = mem_q[rd_ptr_q];
  assign bus.pe_ready = !full;
  assign bus.rtr_valid = rtr_valid_q;
  assign bus.rtr_type  = rtr_type_q;
  assign bus.rtr_data  = rtr_data_q;
  assign fifo_count    = count_q;
  assign dbg_state     = state_q;

  // FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = HEAD;
      end
      HEAD: if (xfer) state_d = BODY;
      BODY: if (xfer) state_d = TAIL;
      TAIL: if (xfer) begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = HEAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next registered flit: a pop loads the head flit directly so packets run back to back
  always_comb begin
    rtr_valid_d = rtr_valid_q;
    rtr_type_d  = rtr_type_q;
    rtr_data_d  = rtr_data_q;
    pkt_d       = pkt_q;
    if (pop) begin
      pkt_d       = head_entry;
      rtr_valid_d = 1'b1;
      rtr_type_d  = 2'b01;
      rtr_data_d  = {head_entry[39:36], head_entry[35:32], XCOORD, YCOORD};
    end else if (xfer) begin
      case (state_q)
        HEAD: begin
          rtr_type_d = 2'b10;
          rtr_data_d = pkt_q[31:16];
        end
        BODY: begin
          rtr_type_d = 2'b11;
          rtr_data_d = pkt_q[15:0];
        end
        default: begin
          rtr_valid_d = 1'b0;
          rtr_type_d  = 2'b00;
          rtr_data_d  = 16'h0000;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_q       <= '0;
      rtr_valid_q <= 1'b0;
      rtr_type_q  <= 2'b00;
      rtr_data_q  <= 16'h0000;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_q       <= pkt_d;
      rtr_valid_q <= rtr_valid_d;
      rtr_type_q  <= rtr_type_d;
      rtr_data_q  <= rtr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.pe_dest_x, bus.pe_dest_y, bus.pe_payload};
  end

`ifdef NI_STATS_EN
  logic [15:0] pkt_count_q, pkt_count_d, stall_count_q, stall_count_d;

  always_comb begin
    pkt_count_d   = pkt_count_q;
    stall_count_d = stall_count_q;
    if (xfer && state_q == TAIL)         pkt_count_d   = pkt_count_q + 16'd1;
    if (rtr_valid_q && !bus.rtr_ready)   stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_noc_local_injector.sv
// Directed bench for noc_local_injector (XCOORD=YCOORD=1, DEPTH=4); honours NI_STATS_EN when defined.
module tb_noc_local_injector;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] fifo_count;
  logic [1:0] dbg_state;
`ifdef NI_STATS_EN
  logic [15:0] pkt_count, stall_count;
  logic [15:0] base_pkt, base_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];

  noc_local_injector_if bus ();

  noc_local_injector #(.XCOORD(4'b0001), .YCOORD(4'b0001), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
`ifdef NI_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] dx, input logic [3:0] dy, input logic [31:0] pl,
                      input bit accept);
    bus.pe_valid   = 1'b1;
    bus.pe_dest_x  = dx;
    bus.pe_dest_y  = dy;
    bus.pe_payload = pl;
    if (accept) begin
      exp_q.push_back({2'b01, dx, dy, 4'h1, 4'h1});
      exp_q.push_back({2'b10, pl[31:16]});
      exp_q.push_back({2'b11, pl[15:0]});
    end
    tick();
    bus.pe_valid = 1'b0;
  endtask

  task automatic expect_flit(input string tag, input logic [1:0] t, input logic [15:0] d);
    check({tag, "_valid"}, bus.rtr_valid, 1'b1);
    check({tag, "_flit"}, {bus.rtr_type, bus.rtr_data}, {t, d});
  endtask

  task automatic drain(input string tag);
    bus.rtr_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (exp_q.size() == 0 && !bus.rtr_valid) break;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_count0"}, fifo_count, 0);
  endtask

  // Scoreboard: every accepted flit must match the next expected one, in order
  always @(negedge clk) begin
    if (!rst && bus.rtr_valid && bus.rtr_ready) begin
      if (exp_q.size() == 0) check("sb_extra_flit", {bus.rtr_type, bus.rtr_data}, 18'h0);
      else check("sb_flit", {bus.rtr_type, bus.rtr_data}, exp_q.pop_front());
    end
  end

  initial begin
    logic [17:0] t2_exp [6];
    bus.pe_valid   = 1'b0;
    bus.pe_dest_x  = '0;
    bus.pe_dest_y  = '0;
    bus.pe_payload = '0;
    bus.rtr_ready  = 1'b0;

    // reset state
    tick(); tick();
    check("rst_pe_ready", bus.pe_ready, 1'b1);
    check("rst_valid", bus.rtr_valid, 1'b0);
    check("rst_type", bus.rtr_type, 2'b00);
    check("rst_data", bus.rtr_data, 16'h0000);
    check("rst_count", fifo_count, 0);
    check("rst_state", dbg_state, 2'd0);
`ifdef NI_STATS_EN
    check("rst_pkt_count", pkt_count, 0);
    check("rst_stall_count", stall_count, 0);
`endif
    rst = 1'b0;

    // single message, latency and flit formats
    bus.rtr_ready = 1'b1;
    send(4'd2, 4'd3, 32'hDEADBEEF, 1'b1);
    check("t1_count_after_push", fifo_count, 1);
    check("t1_not_valid_yet", bus.rtr_valid, 1'b0);
    tick(); expect_flit("t1_head", 2'b01, 16'h2311);
    check("t1_count_after_pop", fifo_count, 0);
    tick(); expect_flit("t1_body", 2'b10, 16'hDEAD);
    tick(); expect_flit("t1_tail", 2'b11, 16'hBEEF);
    tick();
    check("t1_idle_valid", bus.rtr_valid, 1'b0);
    check("t1_idle_type", bus.rtr_type, 2'b00);

    // two back-to-back messages, no gap between packets
    send(4'd5, 4'd6, 32'h12345678, 1'b1);
    send(4'd1, 4'd1, 32'hA5A50F0F, 1'b1);
    t2_exp[0] = {2'b01, 16'h5611};
    t2_exp[1] = {2'b10, 16'h1234};
    t2_exp[2] = {2'b11, 16'h5678};
    t2_exp[3] = {2'b01, 16'h1111};
    t2_exp[4] = {2'b10, 16'hA5A5};
    t2_exp[5] = {2'b11, 16'h0F0F};
    check("t2_count_pushpop", fifo_count, 1);
    for (int i = 0; i < 6; i++) begin
      expect_flit($sformatf("t2_f%0d", i), t2_exp[i][17:16], t2_exp[i][15:0]);
      if (i < 5) tick();
    end
    tick();
    check("t2_idle_valid", bus.rtr_valid, 1'b0);
    check("t2_count_end", fifo_count, 0);

    // body stalled for 5 cycles
`ifdef NI_STATS_EN
    base_pkt   = pkt_count;
    base_stall = stall_count;
`endif
    send(4'd7, 4'd8, 32'hCAFEF00D, 1'b1);
    tick(); expect_flit("t3_head", 2'b01, 16'h7811);
    tick(); expect_flit("t3_body", 2'b10, 16'hCAFE);
    bus.rtr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_flit($sformatf("t3_body_hold%0d", i), 2'b10, 16'hCAFE);
    end
    bus.rtr_ready = 1'b1;
    tick(); expect_flit("t3_tail", 2'b11, 16'hF00D);
    tick();
    check("t3_idle_valid", bus.rtr_valid, 1'b0);
`ifdef NI_STATS_EN
    check("t3_stall_delta", stall_count - base_stall, 5);
    check("t3_pkt_delta", pkt_count - base_pkt, 1);
`endif

    // fill to full with the router blocked, then a rejected push
    bus.rtr_ready = 1'b0;
    send(4'd0, 4'd0, 32'h00000000, 1'b1);
    check("t4_count_m0", fifo_count, 1);
    send(4'd1, 4'd2, 32'h11112222, 1'b1);
    check("t4_count_m1", fifo_count, 1);
    send(4'd3, 4'd4, 32'h33334444, 1'b1);
    check("t4_count_m2", fifo_count, 2);
    send(4'd5, 4'd6, 32'h55556666, 1'b1);
    check("t4_count_m3", fifo_count, 3);
    check("t4_ready_m3", bus.pe_ready, 1'b1);
    send(4'd7, 4'd8, 32'h77778888, 1'b1);
    check("t4_count_full", fifo_count, 4);
    check("t4_ready_full", bus.pe_ready, 1'b0);
    send(4'd9, 4'd9, 32'h99999999, 1'b0);
    check("t4_count_reject", fifo_count, 4);
    expect_flit("t4_head_held", 2'b01, 16'h0011);
    drain("t4");

    // simultaneous push and pop at count 2
    bus.rtr_ready = 1'b0;
    send(4'd2, 4'd2, 32'hAAAA0001, 1'b1);
    send(4'd3, 4'd3, 32'hBBBB0002, 1'b1);
    send(4'd4, 4'd4, 32'hCCCC0003, 1'b1);
    check("t5_count_setup", fifo_count, 2);
    bus.rtr_ready = 1'b1;
    tick(); tick();
    expect_flit("t5_tail_a", 2'b11, 16'h0001);
    check("t5_count_before", fifo_count, 2);
    send(4'd5, 4'd5, 32'hDDDD0004, 1'b1);
    check("t5_count_pushpop", fifo_count, 2);
    expect_flit("t5_head_b", 2'b01, 16'h3311);
    drain("t5");

    // reset while the tail is stalled with 3 messages queued
    bus.rtr_ready = 1'b0;
    send(4'd6, 4'd1, 32'h0A0A0B0B, 1'b1);
    send(4'd6, 4'd2, 32'h0C0C0D0D, 1'b1);
    send(4'd6, 4'd3, 32'h0E0E0F0F, 1'b1);
    send(4'd6, 4'd4, 32'h10102020, 1'b1);
    bus.rtr_ready = 1'b1;
    tick(); tick();
    bus.rtr_ready = 1'b0;
    expect_flit("t6_tail_stalled", 2'b11, 16'h0B0B);
    check("t6_count_queued", fifo_count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t6_valid_after_rst", bus.rtr_valid, 1'b0);
    check("t6_count_after_rst", fifo_count, 0);
    check("t6_ready_after_rst", bus.pe_ready, 1'b1);
    check("t6_state_after_rst", dbg_state, 2'd0);
    bus.rtr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t6_no_stale%0d", i), bus.rtr_valid, 1'b0);
    end
    check("sb_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
